// File: rtl/pixel_frame_buffer_if.sv
// pixel_frame_buffer_if
// Byte-stream write channel into the pixel frame buffer.
// Signals:
//   wr_valid  - producer has a byte on wr_data this cycle
//   wr_data   - packed 12-bit pixel stream, one byte per transfer
//   wr_sof    - marks the current byte as the first byte of a frame
//   wr_ready  - buffer will take the byte this cycle
// Modports:
//   master - the pixel source (drives valid/data/sof)
//   slave  - the frame buffer (drives ready)
interface pixel_frame_buffer_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_sof;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_sof,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_sof,
    output wr_ready
  );
endinterface

// File: rtl/pixel_frame_buffer.sv
// pixel_frame_buffer
// Double-buffered 12-bit grayscale frame store for a row-multiplexed LED
// display. A byte stream carrying two 12-bit pixels per three bytes is
// unpacked into the back bank; once a full frame has landed the block
// holds off further input until the display pulses swap_req at its frame
// boundary, at which point back and front exchange roles.
//
// Parameters:
//   ROWS   - number of multiplexed rows (default 6)
//   WORDS  - 12-bit words per row (default 48 = 3 drivers x 16 channels)
//
// Ports:
//   clock        - system clock, everything on the rising edge
//   reset        - synchronous, active-high reset
//   wr           - write byte stream (pixel_frame_buffer_if.slave)
//   swap_req     - one-cycle pulse at the display frame boundary
//   rd_row       - read row address, 0..ROWS-1
//   rd_word      - read word address, 0..WORDS-1
//   rd_data      - registered grayscale word from the front bank
//   frame_ready  - back bank holds a complete frame awaiting swap
//   sof_err      - sticky: wr_sof arrived while a frame was in progress
//
// Optional feature (macro PIXEL_FRAME_BUFFER_STROBE_EN):
//   An 8-bit swap counter is kept; whenever the front bank is valid and
//   rd_word equals counter[5:0], rd_data is forced to 12'hFFF. This gives a
//   moving bright column for bring-up of the display wiring. With the macro
//   undefined, rd_data is purely the buffer contents.
module pixel_frame_buffer #(
  parameter int ROWS  = 6,
  parameter int WORDS = 48
) (
  input  logic                 clock,
  input  logic                 reset,
  pixel_frame_buffer_if.slave  wr,
  input  logic                 swap_req,
  input  logic [2:0]           rd_row,
  input  logic [5:0]           rd_word,
  output logic [11:0]          rd_data,
  output logic                 frame_ready,
  output logic                 sof_err
);

  localparam int DEPTH  = ROWS * WORDS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] WORDS_A   = ADDR_W'(WORDS);

  // Position within the three-byte group that carries two pixels.
  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } unpack_state_t;

  unpack_state_t     unpack_state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [7:0]        hold_hi;
  logic [3:0]        hold_lo;
  logic              back_bank;
  logic              front_valid;

  // Both banks live in one array indexed by bank, so the write side always
  // targets back_bank and the read side always targets its complement.
  logic [11:0] mem [0:1][0:DEPTH-1];

  logic              accept;
  logic              pix_we;
  logic [11:0]       pix_data;
  logic              rd_in_range;
  logic [ADDR_W-1:0] rd_addr;
  logic              strobe_hit;

  // While a finished frame waits for the display, the stream is stalled so
  // the back bank cannot be overwritten before it becomes the front.
  assign wr.wr_ready = ~frame_ready;
  assign accept      = wr.wr_valid & ~frame_ready;

  // Pixel assembly. A start-of-frame byte is always taken as B0, so it never
  // completes a pixel regardless of where the unpacker was.
  always_comb begin
    pix_we   = 1'b0;
    pix_data = 12'd0;
    if (accept && !wr.wr_sof) begin
      case (unpack_state)
        B1: begin
          pix_we   = 1'b1;
          pix_data = {hold_hi, wr.wr_data[7:4]};
        end
        B2: begin
          pix_we   = 1'b1;
          pix_data = {hold_lo, wr.wr_data};
        end
        default: begin
          pix_we   = 1'b0;
          pix_data = 12'd0;
        end
      endcase
    end
  end

  // Frame storage. Deliberately not cleared by reset: stale contents are
  // hidden by front_valid until a fresh frame has been swapped in.
  always_ff @(posedge clock) begin
    if (pix_we && !reset) begin
      mem[back_bank][wr_ptr] <= pix_data;
    end
  end

`ifdef PIXEL_FRAME_BUFFER_STROBE_EN
  logic [7:0] swap_cnt;

  // Bring-up strobe column follows the number of swaps performed.
  assign strobe_hit = front_valid && (rd_word == swap_cnt[5:0]);

  always_ff @(posedge clock) begin
    if (reset) begin
      swap_cnt <= 8'd0;
    end else if (swap_req && frame_ready) begin
      swap_cnt <= swap_cnt + 8'd1;
    end
  end
`else
  assign strobe_hit = 1'b0;
`endif

  // Write-side control: unpacker state, write pointer, bank roles and flags.
  // A swap and an accepted byte can never coincide, because bytes are only
  // accepted while frame_ready is low and swaps only happen while it is high.
  // A swap_req in the same cycle as the final pixel write therefore sees
  // frame_ready still low and is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      unpack_state <= B0;
      wr_ptr       <= '0;
      hold_hi      <= 8'd0;
      hold_lo      <= 4'd0;
      frame_ready  <= 1'b0;
      sof_err      <= 1'b0;
      back_bank    <= 1'b0;
      front_valid  <= 1'b0;
    end else if (swap_req && frame_ready) begin
      back_bank   <= ~back_bank;
      frame_ready <= 1'b0;
      front_valid <= 1'b1;
      wr_ptr      <= '0;
    end else if (accept) begin
      if (wr.wr_sof) begin
        // Restart the frame; anything partially written is abandoned and
        // will simply be overwritten by the new frame.
        if ((wr_ptr != '0) || (unpack_state != B0)) begin
          sof_err <= 1'b1;
        end
        wr_ptr       <= '0;
        hold_hi      <= wr.wr_data;
        unpack_state <= B1;
      end else begin
        case (unpack_state)
          B0: begin
            hold_hi      <= wr.wr_data;
            unpack_state <= B1;
          end
          B1: begin
            hold_lo      <= wr.wr_data[3:0];
            unpack_state <= B2;
          end
          default: begin
            unpack_state <= B0;
          end
        endcase

        // Both B1 and B2 commit a pixel; the frame ends on whichever one
        // writes the last address, and the unpacker is realigned to B0.
        if (unpack_state != B0) begin
          if (wr_ptr == LAST_ADDR) begin
            wr_ptr       <= '0;
            frame_ready  <= 1'b1;
            unpack_state <= B0;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
          end
        end
      end
    end
  end

  // Read address decode. Row and word are checked separately so that an
  // out-of-range word cannot alias into the next row.
  always_comb begin
    rd_in_range = (int'(rd_row) < ROWS) && (int'(rd_word) < WORDS);
    rd_addr     = ADDR_W'(rd_row) * WORDS_A + ADDR_W'(rd_word);
  end

  // Registered read port with one cycle of latency, always from the bank
  // that is front at the time the address is presented.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= 12'd0;
    end else if (strobe_hit) begin
      rd_data <= 12'hFFF;
    end else if (!front_valid || !rd_in_range) begin
      rd_data <= 12'd0;
    end else begin
      rd_data <= mem[~back_bank][rd_addr];
    end
  end

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// tb_pixel_frame_buffer
// Self-checking bench for pixel_frame_buffer. A frame-level reference model
// collects accepted bytes into a queue, unpacks a whole frame arithmetically
// once it is complete, and presents it as the front image after a swap.
// Outputs are compared against the model every cycle on the falling edge,
// plus constant expectations for the directed scenarios.
module tb_pixel_frame_buffer;

  localparam int ROWS        = 6;
  localparam int WORDS       = 48;
  localparam int DEPTH       = ROWS * WORDS;
  localparam int FRAME_BYTES = DEPTH * 3 / 2;

`ifdef PIXEL_FRAME_BUFFER_STROBE_EN
  localparam bit STROBE_ON = 1'b1;
`else
  localparam bit STROBE_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        swap_req;
  logic [2:0]  rd_row;
  logic [5:0]  rd_word;
  logic [11:0] rd_data;
  logic        frame_ready;
  logic        sof_err;

  pixel_frame_buffer_if bus ();

  pixel_frame_buffer #(
    .ROWS  (ROWS),
    .WORDS (WORDS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wr          (bus),
    .swap_req    (swap_req),
    .rd_row      (rd_row),
    .rd_word     (rd_word),
    .rd_data     (rd_data),
    .frame_ready (frame_ready),
    .sof_err     (sof_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int            m_front [DEPTH];
  int            m_done  [DEPTH];
  bit            m_fv;
  bit            m_fr;
  bit            m_err;
  int            m_cnt;
  int            m_exp_rd;
  byte unsigned  m_q [$];

  // Frame-level model: bytes gather in a queue, a complete frame is turned
  // into pixels with plain arithmetic, and a swap publishes it for reading.
  always @(posedge clock) begin
    if (reset) begin
      m_fv     = 1'b0;
      m_fr     = 1'b0;
      m_err    = 1'b0;
      m_cnt    = 0;
      m_exp_rd = 0;
      m_q.delete();
    end else begin
      if (m_fv && STROBE_ON && (int'(rd_word) == (m_cnt % 64)))
        m_exp_rd = 12'hFFF;
      else if (!m_fv || int'(rd_row) >= ROWS || int'(rd_word) >= WORDS)
        m_exp_rd = 0;
      else
        m_exp_rd = m_front[int'(rd_row) * WORDS + int'(rd_word)];

      if (swap_req && m_fr) begin
        m_front = m_done;
        m_fv    = 1'b1;
        m_fr    = 1'b0;
        m_cnt   = (m_cnt + 1) % 256;
      end else if (bus.wr_valid && !m_fr) begin
        if (bus.wr_sof) begin
          if (m_q.size() != 0) m_err = 1'b1;
          m_q.delete();
        end
        m_q.push_back(bus.wr_data);
        if (m_q.size() == FRAME_BYTES) begin
          for (int k = 0; k < DEPTH / 2; k++) begin
            int b0, b1, b2;
            b0 = int'(m_q[3*k]);
            b1 = int'(m_q[3*k+1]);
            b2 = int'(m_q[3*k+2]);
            m_done[2*k]   = b0 * 16 + b1 / 16;
            m_done[2*k+1] = (b1 % 16) * 256 + b2;
          end
          m_q.delete();
          m_fr = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("rd_data", int'(rd_data), m_exp_rd);
    checkOutput("frame_ready", int'(frame_ready), int'(m_fr));
    checkOutput("sof_err", int'(sof_err), int'(m_err));
    checkOutput("wr_ready", int'(bus.wr_ready), int'(!m_fr));
  endtask

  // One cycle: check what the previous edge produced, then drive new inputs.
  task automatic applyStimulus(input bit rst, input bit v, input logic [7:0] d,
                               input bit sof, input bit swp,
                               input logic [2:0] row, input logic [5:0] word);
    @(negedge clock);
    checkModel();
    reset        = rst;
    bus.wr_valid = v;
    bus.wr_data  = d;
    bus.wr_sof   = sof;
    swap_req     = swp;
    rd_row       = row;
    rd_word      = word;
  endtask

  typedef struct {
    logic [2:0]  row;
    logic [5:0]  word;
    logic [11:0] exp;
  } rd_vec_t;

  rd_vec_t     tbl [8];
  logic [7:0]  pat [3];

  initial begin
    logic [11:0] want;

    tbl[0] = '{3'd0, 6'd0,  12'hABC};
    tbl[1] = '{3'd0, 6'd1,  12'hDEF};
    tbl[2] = '{3'd2, 6'd10, 12'hABC};
    tbl[3] = '{3'd1, 6'd1,  12'hDEF};
    tbl[4] = '{3'd5, 6'd47, 12'hDEF};
    tbl[5] = '{3'd6, 6'd0,  12'h000};
    tbl[6] = '{3'd0, 6'd48, 12'h000};
    tbl[7] = '{3'd7, 6'd63, 12'h000};
    pat[0] = 8'hAB;
    pat[1] = 8'hCD;
    pat[2] = 8'hEF;

    reset        = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'd0;
    bus.wr_sof   = 1'b0;
    swap_req     = 1'b0;
    rd_row       = 3'd0;
    rd_word      = 6'd0;

    // Reset state.
    applyStimulus(1, 0, 8'd0, 0, 0, 3'd0, 6'd0);
    applyStimulus(0, 0, 8'd0, 0, 0, 3'd0, 6'd0);
    checkOutput("reset_rd_data", int'(rd_data), 0);
    checkOutput("reset_wr_ready", int'(bus.wr_ready), 1);
    checkOutput("reset_frame_ready", int'(frame_ready), 0);
    checkOutput("reset_sof_err", int'(sof_err), 0);

    // Known-pattern frame.
    $display("[TB] pattern frame");
    for (int i = 0; i < FRAME_BYTES; i++) begin
      applyStimulus(0, 1, pat[i % 3], i == 0, 0, 3'd0, 6'd0);
      if (i == FRAME_BYTES - 1)
        checkOutput("fr_before_last", int'(frame_ready), 0);
    end
    // Keep offering bytes while the frame waits for the display.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 8'h11, 0, 0, 3'd0, 6'd0);
      checkOutput("fr_held", int'(frame_ready), 1);
      checkOutput("stall_wr_ready", int'(bus.wr_ready), 0);
    end
    checkOutput("pre_swap_rd", int'(rd_data), 0);
    applyStimulus(0, 0, 8'd0, 0, 1, 3'd0, 6'd0);
    applyStimulus(0, 0, 8'd0, 0, 0, 3'd0, 6'd0);
    checkOutput("swap_fr_clear", int'(frame_ready), 0);
    checkOutput("swap_wr_ready", int'(bus.wr_ready), 1);

    // Table-driven reads of the swapped-in pattern frame.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 8'd0, 0, 0, tbl[i].row, tbl[i].word);
      applyStimulus(0, 0, 8'd0, 0, 0, 3'd0, 6'd0);
      want = (STROBE_ON && tbl[i].word == 6'd1) ? 12'hFFF : tbl[i].exp;
      checkOutput($sformatf("tbl_rd[%0d]", i), int'(rd_data), int'(want));
    end

    // Interrupted frame followed by a clean restart.
    $display("[TB] sof restart");
    for (int i = 0; i < 100; i++)
      applyStimulus(0, 1, 8'($urandom), i == 0, 0, 3'd0, 6'd0);
    checkOutput("no_err_yet", int'(sof_err), 0);
    applyStimulus(0, 1, 8'($urandom), 1, 0, 3'd0, 6'd0);
    for (int i = 0; i < FRAME_BYTES - 1; i++) begin
      applyStimulus(0, 1, 8'($urandom), 0, 0, 3'd0, 6'd0);
      if (i == 0) checkOutput("sof_err_set", int'(sof_err), 1);
    end
    applyStimulus(0, 0, 8'd0, 0, 0, 3'd0, 6'd0);
    checkOutput("restart_fr", int'(frame_ready), 1);
    applyStimulus(0, 0, 8'd0, 0, 1, 3'd0, 6'd0);
    for (int i = 0; i < 40; i++)
      applyStimulus(0, 0, 8'd0, 0, 0, 3'(($urandom % 6)), 6'(($urandom % 48)));

    // swap_req coincident with the final pixel write must not swap.
    $display("[TB] coincident swap");
    for (int i = 0; i < FRAME_BYTES; i++)
      applyStimulus(0, 1, 8'($urandom), i == 0, i == FRAME_BYTES - 1, 3'd0, 6'd3);
    applyStimulus(0, 0, 8'd0, 0, 0, 3'd0, 6'd3);
    checkOutput("coinc_fr_kept", int'(frame_ready), 1);
    applyStimulus(0, 0, 8'd0, 0, 1, 3'd0, 6'd3);
    applyStimulus(0, 0, 8'd0, 0, 0, 3'd6, 6'd4);
    checkOutput("coinc_swapped", int'(frame_ready), 0);
    applyStimulus(0, 0, 8'd0, 0, 0, 3'd0, 6'd0);
    checkOutput("row6_zero", int'(rd_data), 0);

    // Randomized traffic, including stray swaps and an occasional reset.
    $display("[TB] random traffic");
    for (int i = 0; i < 6000; i++) begin
      applyStimulus(($urandom % 1500) == 0,
                    ($urandom % 4) != 0,
                    8'($urandom),
                    ($urandom % 2000) == 0,
                    ($urandom % 50) == 0,
                    3'($urandom),
                    6'($urandom));
    end
    applyStimulus(0, 0, 8'd0, 0, 0, 3'd0, 6'd0);
    @(negedge clock);
    checkModel();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
